// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
//
// Program-counter generator for the IF stage of the 5-stage MIPS pipeline.
// It holds the fetch PC and selects the next PC from one of these sources:
// the sequential step, a taken branch, a jump, the exception vector or an
// ERET return address. Stalls hold the PC. A redirect that arrives during a
// stall is parked in a one-entry buffer and is applied on the first edge
// after the stall ends. Misaligned eret, branch and jump targets are trapped
// to the exception vector, and the offending address is reported.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   stall_i       in   hold the PC
//   br_take_i     in   taken branch resolved in ID
//   br_target_i   in   branch target
//   jmp_take_i    in   j/jal/jr/jalr in ID
//   jmp_target_i  in   jump target
//   exc_req_i     in   exception request from a later stage
//   eret_req_i    in   ERET return request
//   epc_i         in   ERET return address
//   pc_o          out  current fetch PC (registered)
//   pc_step_o     out  pc_o + STEP (combinational, wraps)
//   link_o        out  pc_o + LINK_OFFSET (combinational, wraps)
//   valid_o       out  pc_o holds a fetchable address
//   pend_o        out  a redirect is buffered
//   misalign_o    out  one-cycle pulse while pc_o shows a trapped target
//   bad_addr_o    out  last misaligned target (registered)
// ---------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      LINK_OFFSET  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             br_take_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             jmp_take_i,
    input  logic [WIDTH-1:0] jmp_target_i,
    input  logic             exc_req_i,
    input  logic             eret_req_i,
    input  logic [WIDTH-1:0] epc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_step_o,
    output logic [WIDTH-1:0] link_o,
    output logic             valid_o,
    output logic             pend_o,
    output logic             misalign_o,
    output logic [WIDTH-1:0] bad_addr_o
);

    // Redirect priority classes; a larger value wins.
    typedef enum logic [1:0] {
        CLS_JMP  = 2'd0,
        CLS_BR   = 2'd1,
        CLS_ERET = 2'd2,
        CLS_EXC  = 2'd3
    } redirect_cls_e;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LINK_W     = WIDTH'(LINK_OFFSET);
    // STEP is a power of two, so "target mod STEP" is the low bits under this mask.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    // Architectural state
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] bad_q, bad_d;

    // Pending-redirect buffer: resolved target, priority class, and whether
    // the entry is a trapped misalignment (with its original address).
    logic             buf_vld_q, buf_vld_d;
    redirect_cls_e    buf_cls_q, buf_cls_d;
    logic [WIDTH-1:0] buf_tgt_q, buf_tgt_d;
    logic             buf_mis_q, buf_mis_d;
    logic [WIDTH-1:0] buf_bad_q, buf_bad_d;

    // Highest-priority live request this cycle
    logic             live_vld;
    redirect_cls_e    live_cls;
    logic [WIDTH-1:0] live_raw;
    logic             live_mis;
    logic [WIDTH-1:0] live_tgt;

    // Pick the winning live request; lower-priority ones in the same cycle
    // are simply not seen.
    always_comb begin
        live_vld = 1'b1;
        live_cls = CLS_JMP;
        live_raw = jmp_target_i;
        if (exc_req_i) begin
            live_cls = CLS_EXC;
            live_raw = EXC_VECTOR;
        end else if (eret_req_i) begin
            live_cls = CLS_ERET;
            live_raw = epc_i;
        end else if (br_take_i) begin
            live_cls = CLS_BR;
            live_raw = br_target_i;
        end else if (jmp_take_i) begin
            live_cls = CLS_JMP;
            live_raw = jmp_target_i;
        end else begin
            live_vld = 1'b0;
        end
    end

    // The exception vector itself is trusted and never alignment-checked.
    assign live_mis = live_vld && (live_cls != CLS_EXC) && ((live_raw & ALIGN_MASK) != '0);
    assign live_tgt = live_mis ? EXC_VECTOR : live_raw;

    // Next-state selection. The first edge after reset release only raises
    // valid, so RESET_VECTOR is itself fetched with valid set. An exception
    // beats a stall and flushes the buffer. During a stall the PC holds and
    // a live request may claim the buffer if it is empty or the request is at
    // least as important as the parked entry. When running, a parked entry
    // is used only if it strictly outranks whatever is live now.
    always_comb begin
        pc_d      = pc_q;
        valid_d   = 1'b1;
        mis_d     = 1'b0;
        bad_d     = bad_q;
        buf_vld_d = buf_vld_q;
        buf_cls_d = buf_cls_q;
        buf_tgt_d = buf_tgt_q;
        buf_mis_d = buf_mis_q;
        buf_bad_d = buf_bad_q;

        if (!valid_q) begin
            pc_d = pc_q;
        end else if (exc_req_i) begin
            pc_d      = EXC_VECTOR;
            buf_vld_d = 1'b0;
        end else if (stall_i) begin
            if (live_vld && (!buf_vld_q || (live_cls >= buf_cls_q))) begin
                buf_vld_d = 1'b1;
                buf_cls_d = live_cls;
                buf_tgt_d = live_tgt;
                buf_mis_d = live_mis;
                buf_bad_d = live_raw;
            end
        end else begin
            buf_vld_d = 1'b0;
            if (buf_vld_q && (!live_vld || (buf_cls_q > live_cls))) begin
                pc_d  = buf_tgt_q;
                mis_d = buf_mis_q;
                if (buf_mis_q) begin
                    bad_d = buf_bad_q;
                end
            end else if (live_vld) begin
                pc_d  = live_tgt;
                mis_d = live_mis;
                if (live_mis) begin
                    bad_d = live_raw;
                end
            end else begin
                pc_d = pc_q + STEP_W;
            end
        end
    end

    // State registers; reset also discards any parked redirect at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VECTOR;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            bad_q     <= '0;
            buf_vld_q <= 1'b0;
            buf_cls_q <= CLS_JMP;
            buf_tgt_q <= '0;
            buf_mis_q <= 1'b0;
            buf_bad_q <= '0;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            bad_q     <= bad_d;
            buf_vld_q <= buf_vld_d;
            buf_cls_q <= buf_cls_d;
            buf_tgt_q <= buf_tgt_d;
            buf_mis_q <= buf_mis_d;
            buf_bad_q <= buf_bad_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_step_o  = pc_q + STEP_W;
    assign link_o     = pc_q + LINK_W;
    assign valid_o    = valid_q;
    assign pend_o     = buf_vld_q;
    assign misalign_o = mis_q;
    assign bad_addr_o = bad_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_unit
//
// Bench for pc_gen_unit. One instance uses the default 32-bit configuration
// and one uses WIDTH=16, STEP=2 for the wrap-around case. Directed scenarios
// come first, then a randomized run compared cycle by cycle against a
// behavioural model of the PC rules.
// ---------------------------------------------------------------------------
module tb_pc_gen_unit;

    localparam int unsigned EXC = 32'h0000_4180;
    localparam int unsigned RST = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_take = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc, pc_step, link, bad_addr;
    logic        valid, pend, misalign;

    logic        jmp16 = 1'b0;
    logic [15:0] jmp_target16 = '0;
    logic [15:0] pc16, pc_step16, link16, bad_addr16;
    logic        valid16, pend16, misalign16;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_valid;
    int unsigned m_pc;
    bit          m_pend;
    int          m_bcls;
    int unsigned m_braw;
    bit          m_mis;
    int unsigned m_bad;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .br_take_i(br_take), .br_target_i(br_target),
        .jmp_take_i(jmp_take), .jmp_target_i(jmp_target),
        .exc_req_i(exc_req), .eret_req_i(eret_req), .epc_i(epc),
        .pc_o(pc), .pc_step_o(pc_step), .link_o(link), .valid_o(valid),
        .pend_o(pend), .misalign_o(misalign), .bad_addr_o(bad_addr)
    );

    pc_gen_unit #(
        .WIDTH(16), .STEP(2), .LINK_OFFSET(4),
        .RESET_VECTOR(16'hFFF0), .EXC_VECTOR(16'h0180)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .stall_i(1'b0),
        .br_take_i(1'b0), .br_target_i(16'h0000),
        .jmp_take_i(jmp16), .jmp_target_i(jmp_target16),
        .exc_req_i(1'b0), .eret_req_i(1'b0), .epc_i(16'h0000),
        .pc_o(pc16), .pc_step_o(pc_step16), .link_o(link16), .valid_o(valid16),
        .pend_o(pend16), .misalign_o(misalign16), .bad_addr_o(bad_addr16)
    );

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; br_take = 1'b0; jmp_take = 1'b0;
        exc_req = 1'b0; eret_req = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = RST; m_pend = 0; m_bcls = 0;
        m_braw = 0; m_mis = 0; m_bad = 0;
    endtask

    // Model of one clock edge, written from the PC rules directly:
    // priority exc(3) > eret(2) > br(1) > jmp(0), alignment is mod 4.
    task automatic model_edge();
        int          cls;
        int unsigned raw;
        int unsigned t;
        bit          bad;
        if (!m_valid) begin
            m_valid = 1; m_mis = 0;
            return;
        end
        cls = -1; raw = 0;
        if (exc_req)        begin cls = 3; raw = EXC; end
        else if (eret_req)  begin cls = 2; raw = epc; end
        else if (br_take)   begin cls = 1; raw = br_target; end
        else if (jmp_take)  begin cls = 0; raw = jmp_target; end
        if (exc_req) begin
            m_pc = EXC; m_pend = 0; m_mis = 0;
        end else if (stall) begin
            m_mis = 0;
            if (cls >= 0 && (!m_pend || cls >= m_bcls)) begin
                m_pend = 1; m_bcls = cls; m_braw = raw;
            end
        end else begin
            if (m_pend && (cls < 0 || m_bcls > cls)) t = m_braw;
            else if (cls >= 0) t = raw;
            else t = m_pc + 4;
            bad = ((m_pend && (cls < 0 || m_bcls > cls)) || cls >= 0) && (t % 4 != 0);
            if (bad) begin m_bad = t; m_pc = EXC; end
            else m_pc = t;
            m_mis = bad;
            m_pend = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        checks++; if (pc !== RST) begin failures++; $display("[TB] FAIL reset_pc got %h want %h", pc, RST); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
        checks++; if (pend !== 1'b0 || misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got pend=%b mis=%b want 0 0", pend, misalign); end
        checks++; if (bad_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_bad got %h want 0", bad_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (valid !== 1'b1 || pc !== RST) begin failures++; $display("[TB] FAIL valid_rise got valid=%b pc=%h want 1 %h", valid, pc, RST); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (pc !== 32'h3004) begin failures++; $display("[TB] FAIL seq1 got %h want 3004", pc); end
        tick();
        checks++; if (pc !== 32'h3008) begin failures++; $display("[TB] FAIL seq2 got %h want 3008", pc); end
        checks++; if (link !== 32'h3010) begin failures++; $display("[TB] FAIL link got %h want 3010", link); end
        checks++; if (pc_step !== 32'h300C) begin failures++; $display("[TB] FAIL pc_step got %h want 300c", pc_step); end
    endtask

    task automatic test_priority();
        br_take = 1'b1; br_target = 32'h3100;
        jmp_take = 1'b1; jmp_target = 32'h3200;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h3100) begin failures++; $display("[TB] FAIL br_over_jmp got %h want 3100", pc); end
    endtask

    task automatic test_stall_buffer();
        stall = 1'b1; jmp_take = 1'b1; jmp_target = 32'h3400;
        tick();
        jmp_take = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pc !== 32'h3100 || pend !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold%0d got pc=%h pend=%b want 3100 1", i, pc, pend); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h3400 || pend !== 1'b0) begin failures++; $display("[TB] FAIL stall_release got pc=%h pend=%b want 3400 0", pc, pend); end
        tick();
        checks++; if (pc !== 32'h3404) begin failures++; $display("[TB] FAIL after_buffer got %h want 3404", pc); end
    endtask

    task automatic test_misalign();
        br_take = 1'b1; br_target = 32'h3102;
        tick();
        clear_inputs();
        checks++; if (pc !== EXC || misalign !== 1'b1) begin failures++; $display("[TB] FAIL misalign_trap got pc=%h mis=%b want %h 1", pc, misalign, EXC); end
        checks++; if (bad_addr !== 32'h3102) begin failures++; $display("[TB] FAIL bad_addr got %h want 3102", bad_addr); end
        tick();
        checks++; if (misalign !== 1'b0 || pc !== 32'h4184) begin failures++; $display("[TB] FAIL misalign_pulse got mis=%b pc=%h want 0 4184", misalign, pc); end
    endtask

    task automatic test_exc_stall();
        stall = 1'b1; jmp_take = 1'b1; jmp_target = 32'h3400;
        tick();
        jmp_take = 1'b0;
        checks++; if (pend !== 1'b1 || pc !== 32'h4184) begin failures++; $display("[TB] FAIL exc_pre got pend=%b pc=%h want 1 4184", pend, pc); end
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        checks++; if (pc !== EXC || pend !== 1'b0) begin failures++; $display("[TB] FAIL exc_in_stall got pc=%h pend=%b want %h 0", pc, pend, EXC); end
        tick();
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h4184) begin failures++; $display("[TB] FAIL exc_flush got %h want 4184", pc); end
        eret_req = 1'b1; epc = 32'h3020;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h3020) begin failures++; $display("[TB] FAIL eret got %h want 3020", pc); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; jmp_take = 1'b1; jmp_target = 32'h3500;
        tick();
        jmp_take = 1'b0;
        checks++; if (pend !== 1'b1) begin failures++; $display("[TB] FAIL async_pre got pend=%b want 1", pend); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== RST || pend !== 1'b0 || valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset got pc=%h pend=%b valid=%b want %h 0 0", pc, pend, valid, RST); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 32'h3004) begin failures++; $display("[TB] FAIL async_after got %h want 3004", pc); end
    endtask

    task automatic test_wrap16();
        jmp16 = 1'b1; jmp_target16 = 16'hFFFE;
        tick();
        jmp16 = 1'b0;
        checks++; if (pc16 !== 16'hFFFE || pc_step16 !== 16'h0000 || link16 !== 16'h0002) begin failures++; $display("[TB] FAIL wrap_pre got pc=%h step=%h link=%h want fffe 0000 0002", pc16, pc_step16, link16); end
        tick();
        checks++; if (pc16 !== 16'h0000 || pc_step16 !== 16'h0002) begin failures++; $display("[TB] FAIL wrap got pc=%h step=%h want 0000 0002", pc16, pc_step16); end
        jmp16 = 1'b1; jmp_target16 = 16'h0101;
        tick();
        jmp16 = 1'b0;
        checks++; if (pc16 !== 16'h0180 || misalign16 !== 1'b1 || bad_addr16 !== 16'h0101) begin failures++; $display("[TB] FAIL wrap_mis got pc=%h mis=%b bad=%h want 0180 1 0101", pc16, misalign16, bad_addr16); end
    endtask

    task automatic test_random();
        int unsigned t;
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 2) == 0);
            exc_req  = ($urandom_range(0, 15) == 0);
            eret_req = ($urandom_range(0, 7) == 0);
            br_take  = ($urandom_range(0, 3) == 0);
            jmp_take = ($urandom_range(0, 3) == 0);
            t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3; br_target = t;
            t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3; jmp_target = t;
            t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3; epc = t;
            @(posedge clk);
            model_edge();
            #1;
            checks++; if (pc !== m_pc) begin failures++; $display("[TB] FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
            checks++; if (pend !== m_pend) begin failures++; $display("[TB] FAIL rnd_pend cyc %0d got %b want %b", i, pend, m_pend); end
            checks++; if (misalign !== m_mis || bad_addr !== m_bad) begin failures++; $display("[TB] FAIL rnd_mis cyc %0d got %b/%h want %b/%h", i, misalign, bad_addr, m_mis, m_bad); end
            checks++; if (valid !== m_valid) begin failures++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, valid, m_valid); end
            checks++; if (link !== m_pc + 32'd8 || pc_step !== m_pc + 32'd4) begin failures++; $display("[TB] FAIL rnd_link cyc %0d got %h/%h want %h/%h", i, link, pc_step, m_pc + 32'd8, m_pc + 32'd4); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_stall_buffer();
        test_misalign();
        test_exc_stall();
        test_async_reset();
        test_wrap16();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the 5-stage MIPS pipeline: holds the fetch PC and selects next-PC from sequential step, branch, jump, exception vector or ERET return.
- Generalises the fixed PC+8 link adder: configurable width, step and link offset, with stall handling, a one-entry pending-redirect buffer and misaligned-target trapping.
- Sits at the IF stage. It drives instruction-memory address and the link value to IF/ID.

Parameters:
- WIDTH, 32, address width in bits; all arithmetic is modulo 2^WIDTH.
- STEP, 4, sequential increment in bytes; must be a power of two, at least 1.
- LINK_OFFSET, 8, offset added to pc_o for link_o (jal/jalr return address past the delay slot).
- RESET_VECTOR, 32'h0000_3000, PC value loaded at reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC (load-use or memory stall).
- br_take_i  in  1  taken branch resolved in ID.
- br_target_i  in  WIDTH  branch target.
- jmp_take_i  in  1  j/jal/jr/jalr in ID.
- jmp_target_i  in  WIDTH  jump target.
- exc_req_i  in  1  exception request from a later stage.
- eret_req_i  in  1  ERET return request.
- epc_i  in  WIDTH  ERET return address.
- pc_o  out  WIDTH  current fetch PC (registered).
- pc_step_o  out  WIDTH  pc_o + STEP (combinational).
- link_o  out  WIDTH  pc_o + LINK_OFFSET (combinational).
- valid_o  out  1  pc_o holds a fetchable address.
- pend_o  out  1  a redirect is buffered.
- misalign_o  out  1  one-cycle pulse: a redirect target was misaligned and was trapped.
- bad_addr_o  out  WIDTH  last misaligned target (registered).

Behaviour:
- Reset (async assert, sync release on clk edge) sets:
  - pc_o = RESET_VECTOR
  - valid_o = 0
  - pend_o = 0
  - misalign_o = 0
  - bad_addr_o = 0
  - the pending buffer is cleared.
- Reset asserted mid-operation discards any buffered redirect immediately.
- valid_o rises on the first clk edge after rst_n is high and stays 1.
- Redirect priority, highest first: exc_req_i > eret_req_i > br_take_i > jmp_take_i. Lower-priority requests asserted in the same cycle are dropped.
- Candidate target:
  - exc_req_i: EXC_VECTOR
  - eret_req_i: epc_i
  - br_take_i: br_target_i
  - jmp_take_i: jmp_target_i
- Alignment rule: a target is aligned iff target mod STEP = 0. The rule applies only to eret, branch and jump targets; EXC_VECTOR is never checked.
- Misaligned target:
  - The target is replaced by EXC_VECTOR.
  - bad_addr_o takes the offending target.
  - misalign_o pulses high for exactly the cycle in which pc_o takes EXC_VECTOR.
- Next-state each edge, stall_i = 0:
  - If a redirect is present this cycle, pc_o takes its target. A buffered redirect is used only if no higher-or-equal-priority live redirect is present.
  - Otherwise, if the buffer is full, pc_o takes the buffered target.
  - Otherwise pc_o takes pc_o + STEP.
  - The buffer is cleared.
- Next-state each edge, stall_i = 1:
  - pc_o holds.
  - Any live redirect is written into the buffer (after alignment check) if the buffer is empty, or if its priority is at least that of the buffered entry. Otherwise it is dropped.
  - pend_o = buffer full.
- The buffer stores the resolved target plus its priority class (2 bits). Its contents are applied on the first non-stalled edge: latency is exactly 1 edge after stall_i falls.
- exc_req_i overrides stall: the PC loads EXC_VECTOR even when stall_i = 1, and the buffer is cleared.
- Wrap-around: pc_o = 2^WIDTH - STEP steps to 0 with no flag. pc_step_o and link_o also wrap.
- Sequential and redirect latency: a request at edge N is visible on pc_o after edge N.

Test Plan:
- Reset release, defaults, no stall: pc_o = 0x3000 during reset with valid_o = 0; then 0x3004, 0x3008; link_o = 0x3010 when pc_o = 0x3008.
- At pc_o = 0x3008, assert br_take_i (target 0x3100) and jmp_take_i (target 0x3200) together → pc_o = 0x3100 next cycle.
- stall_i high 3 cycles, jmp target 0x3400 in cycle 1:
  - pc_o holds and pend_o = 1 through the stall.
  - pc_o = 0x3400 one edge after stall falls; pend_o returns to 0.
- br_take_i with target 0x3102 → pc_o = 0x4180, misalign_o pulses 1 cycle, bad_addr_o = 0x3102.
- stall_i = 1 with exc_req_i → pc_o = 0x4180 immediately. Buffered jump is discarded; eret with epc 0x3020 later → pc_o = 0x3020.
- WIDTH = 16, STEP = 2, PC = 0xFFFE → next pc_o = 0x0000, pc_step_o = 0x0002.
- Assert rst_n low mid-stall with a pending redirect → pc_o = RESET_VECTOR asynchronously, pend_o = 0.
